rpu_rcv_rsp_arb_encode: RTL and testbench
=========================================

# rpu_rcv_rsp_arb_encode

Multi-channel receive-response encoder for the NOU RPU. Each of `NUM_CH` receive channels posts per-packet descriptors (header size, data size, header buffer address, data buffer address) into its own small FIFO. A round-robin arbiter picks one descriptor per cycle, packs it into an XOCC response command word tagged with the source channel and an optional sequence number, and presents it on a single valid/ready output port.

## Interface
- `NUM_CH`, default 4: number of receive channels, 1..16.
- `DEPTH`, default 4: per-channel FIFO entries; power of two, ≥2.
- `HS_W`, default `` `NOU_PKT_HEADER_SZ_WIDTH ``: header size width.
- `DS_W`, default `` `NOU_PKT_DATA_SZ_WIDTH ``: data size width.
- `HA_W`, default `` `NOU_PKT_HEADER_ADDR_WIDTH ``: header buffer address width.
- `DA_W`, default `` `NOU_PKT_DATA_ADDR_WIDTH ``: data buffer address width.
- `CMD_W`, default `` `NOU_XOCC_CMD_WIDTH ``: output command width.
- `TYPE_W`, default 4: response type field width.
- `RSP_TYPE`, default `` `RCV_PKT_RSP_TYPE ``: constant placed in the type field.
- Derived: `CH_W = max(1, $clog2(NUM_CH))`; `SEQ_W = 8`. Elaboration error if `CMD_W < TYPE_W+DS_W+DA_W+CH_W+SEQ_W+HS_W+HA_W`.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in `NUM_CH`: per-channel descriptor valid.
- `in_ready` out `NUM_CH`: per-channel accept.
- `in_hdr_sz` in `NUM_CH*HS_W`: packed per-channel header size; channel i occupies `[i*HS_W +: HS_W]`.
- `in_data_sz` in `NUM_CH*DS_W`: packed per-channel data size.
- `in_hdr_addr` in `NUM_CH*HA_W`: packed per-channel header buffer address.
- `in_data_addr` in `NUM_CH*DA_W`: packed per-channel data buffer address.
- `out_valid` out 1: command valid.
- `out_ready` in 1: downstream accept.
- `out_cmd` out `CMD_W`: encoded response.
- `out_ch` out `CH_W`: source channel of `out_cmd`.
- `ovf` out `NUM_CH`: sticky per-channel "valid while not ready" flag.

## Operation
- Push: channel i writes its FIFO when `in_valid[i] && in_ready[i]`. `in_ready[i] = !full[i] && !rst`.
- No push/pop bypass: a full FIFO rejects a push even when it is popped in the same cycle.
- `in_valid[i] && !in_ready[i] && !rst` sets `ovf[i]`. The descriptor is dropped. The flag clears only on reset.
- Output register stage: the register is "free" when `!out_valid || out_ready`. When free and any FIFO is non-empty, the arbiter grants one channel, pops it, and loads `out_cmd`/`out_ch`. When free and all FIFOs are empty, `out_valid` drops to 0.
- Round-robin: search starts at `last_grant+1` modulo `NUM_CH`. The first non-empty channel wins and becomes `last_grant`. `last_grant` resets to `NUM_CH-1`, so channel 0 has first priority.
- `out_cmd` layout, LSB first:
  - `[TYPE_W-1:0]` = `RSP_TYPE`
  - data size
  - data buffer address
  - channel id (`CH_W`)
  - sequence (`SEQ_W`)
  - header size
  - header buffer address
  - remaining MSBs zero.
- Sequence field: see Configuration. The counter is per channel and wraps 255→0 with no flag.
- While `out_valid && !out_ready`, `out_cmd` and `out_ch` are held stable.

## Timing
- Reset values: `out_valid=0`, `out_cmd=0`, `out_ch=0`, `ovf=0`, all FIFOs empty, all sequence counters 0, `last_grant=NUM_CH-1`.
- `in_ready=0` during any cycle with `rst=1`.
- Latency: a descriptor accepted at edge k into an empty FIFO, with the output stage free, is loaded at edge k+1. `out_valid` is high in the cycle after edge k+1, giving 2 cycles of latency.
- Throughput: one command per cycle sustained when `out_ready=1`.
- With all channels continuously non-empty, grants rotate 0,1,…,NUM_CH-1.
- Reset mid-operation: all buffered descriptors and a pending `out_cmd` are discarded, with no partial output.
- Each FIFO uses a registered count/pointer implementation. Pointers are `$clog2(DEPTH)` bits, with a separate full/empty count of `$clog2(DEPTH)+1` bits.

## Configuration
- `RPU_RCV_RSP_SEQ_EN` defined: each channel keeps an 8-bit counter. The counter value is placed in the sequence field at load time, then the counter increments on each grant of that channel.
- `RPU_RCV_RSP_SEQ_EN` undefined: the sequence field is constant 0 and no counters are built. Field positions are identical in both builds.

## Test plan
- Reset then single push on ch2 (hdr_sz=5, data_sz=0x40, hdr_addr=0x12, data_addr=0x300) with `out_ready=1` -> `out_valid` exactly 2 cycles later. Fields decode to these values, ch id=2, type=`RSP_TYPE`, seq=0, pad bits 0.
- All 4 channels push DEPTH entries simultaneously, `out_ready=1` -> 16 outputs in order ch0,1,2,3,0,1,… with no idle cycles once started.
- Backpressure: `out_ready=0` for 10 cycles with ch1 continuously valid -> `out_cmd` is stable. `in_ready[1]` drops after DEPTH accepts. Continued `in_valid[1]` sets `ovf[1]`. After release, exactly DEPTH+1 ch1 outputs with no loss of accepted entries.
- Full FIFO with simultaneous pop and push -> push rejected that cycle. `ovf` is set because valid was held.
- Assert `rst` while 3 entries are buffered and `out_valid=1` -> next cycle `out_valid=0`, `ovf=0`. No stale entries appear after reset.
- With `RPU_RCV_RSP_SEQ_EN`: 257 ch0 packets -> seq values 0..255, then 0. Without the macro -> the seq field is always 0.

Source files
------------

// File: rtl/rpu_rcv_rsp_arb_encode.sv
// Receive-response encoder: per-channel descriptor FIFOs, round-robin arbiter and a registered
// XOCC response command stage. Define RPU_RCV_RSP_SEQ_EN to build per-channel sequence counters.
`ifndef NOU_PKT_HEADER_SZ_WIDTH
`define NOU_PKT_HEADER_SZ_WIDTH 8
`endif
`ifndef NOU_PKT_DATA_SZ_WIDTH
`define NOU_PKT_DATA_SZ_WIDTH 16
`endif
`ifndef NOU_PKT_HEADER_ADDR_WIDTH
`define NOU_PKT_HEADER_ADDR_WIDTH 16
`endif
`ifndef NOU_PKT_DATA_ADDR_WIDTH
`define NOU_PKT_DATA_ADDR_WIDTH 16
`endif
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 128
`endif
`ifndef RCV_PKT_RSP_TYPE
`define RCV_PKT_RSP_TYPE 4'h3
`endif

module rpu_rcv_rsp_arb_encode #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int HS_W   = `NOU_PKT_HEADER_SZ_WIDTH,
    parameter int DS_W   = `NOU_PKT_DATA_SZ_WIDTH,
    parameter int HA_W   = `NOU_PKT_HEADER_ADDR_WIDTH,
    parameter int DA_W   = `NOU_PKT_DATA_ADDR_WIDTH,
    parameter int CMD_W  = `NOU_XOCC_CMD_WIDTH,
    parameter int TYPE_W = 4,
    parameter logic [TYPE_W-1:0] RSP_TYPE = `RCV_PKT_RSP_TYPE,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      in_valid,
    output logic [NUM_CH-1:0]      in_ready,
    input  logic [NUM_CH*HS_W-1:0] in_hdr_sz,
    input  logic [NUM_CH*DS_W-1:0] in_data_sz,
    input  logic [NUM_CH*HA_W-1:0] in_hdr_addr,
    input  logic [NUM_CH*DA_W-1:0] in_data_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CMD_W-1:0]       out_cmd,
    output logic [CH_W-1:0]        out_ch,
    output logic [NUM_CH-1:0]      ovf
);
    localparam int SEQ_W   = 8;
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int ENT_W   = HA_W + HS_W + DA_W + DS_W;
    localparam int FIELD_W = TYPE_W + DS_W + DA_W + CH_W + SEQ_W + HS_W + HA_W;

    generate
        if (CMD_W < FIELD_W) begin : g_width_check
            $error("CMD_W too narrow for the response fields");
        end
    endgenerate

    // Entries are stored as {hdr_addr, hdr_sz, data_addr, data_sz}
    logic [ENT_W-1:0]  mem    [NUM_CH][DEPTH];
    logic [PW-1:0]     wr_ptr [NUM_CH];
    logic [PW-1:0]     rd_ptr [NUM_CH];
    logic [CW-1:0]     count  [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic              load;
    logic [ENT_W-1:0]  grant_ent;
    logic [SEQ_W-1:0]  grant_seq;
    logic [CMD_W-1:0]  cmd_next;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]  = (count[i] == CW'(DEPTH));
            empty[i] = (count[i] == '0);
        end
    end

    assign in_ready = ~full & {NUM_CH{~rst}};
    assign push     = in_valid & in_ready;
    assign load     = (!out_valid || out_ready) && grant_vld;

    // Search begins just after the previous winner so every channel gets a turn
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load) pop[grant_idx] = 1'b1;
    end

    assign grant_ent = mem[grant_idx][rd_ptr[grant_idx]];

`ifdef RPU_RCV_RSP_SEQ_EN
    logic [SEQ_W-1:0] seq_cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) seq_cnt[i] <= '0;
        end else if (load) begin
            seq_cnt[grant_idx] <= seq_cnt[grant_idx] + SEQ_W'(1);
        end
    end

    assign grant_seq = seq_cnt[grant_idx];
`else
    assign grant_seq = '0;
`endif

    always_comb begin
        cmd_next = '0;
        cmd_next[FIELD_W-1:0] = {grant_ent[ENT_W-1 -: HA_W+HS_W], grant_seq, grant_idx,
                                 grant_ent[DA_W+DS_W-1:0], RSP_TYPE};
    end

    // A full FIFO refuses pushes even when popped in the same cycle, so count never overshoots
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {in_hdr_addr[i*HA_W +: HA_W], in_hdr_sz[i*HS_W +: HS_W],
                                      in_data_addr[i*DA_W +: DA_W], in_data_sz[i*DS_W +: DS_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf        <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            out_valid  <= 1'b0;
            out_cmd    <= '0;
            out_ch     <= '0;
        end else begin
            ovf <= ovf | (in_valid & ~in_ready);
            if (load) begin
                last_grant <= grant_idx;
                out_valid  <= 1'b1;
                out_cmd    <= cmd_next;
                out_ch     <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rpu_rcv_rsp_arb_encode.sv
// Directed bench for rpu_rcv_rsp_arb_encode: stimulus pushes expected commands into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_rpu_rcv_rsp_arb_encode;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int HS_W   = 8;
    localparam int DS_W   = 16;
    localparam int HA_W   = 16;
    localparam int DA_W   = 16;
    localparam int CMD_W  = 128;
    localparam int TYPE_W = 4;
    localparam logic [TYPE_W-1:0] RSP_TYPE = 4'h3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_CH-1:0]      in_valid = '0;
    logic [NUM_CH-1:0]      in_ready;
    logic [NUM_CH*HS_W-1:0] in_hdr_sz = '0;
    logic [NUM_CH*DS_W-1:0] in_data_sz = '0;
    logic [NUM_CH*HA_W-1:0] in_hdr_addr = '0;
    logic [NUM_CH*DA_W-1:0] in_data_addr = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [CMD_W-1:0]       out_cmd;
    logic [1:0]             out_ch;
    logic [NUM_CH-1:0]      ovf;

    typedef struct {
        logic [1:0]       ch;
        logic [CMD_W-1:0] cmd;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   seqModel[NUM_CH];
    int   cyc = 0;
    int   seenOut = 0;
    int   markCount = 0;
    int   firstCyc = 0;
    int   lastCyc = 0;

    rpu_rcv_rsp_arb_encode #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .HS_W(HS_W), .DS_W(DS_W), .HA_W(HA_W),
        .DA_W(DA_W), .CMD_W(CMD_W), .TYPE_W(TYPE_W), .RSP_TYPE(RSP_TYPE)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_hdr_sz(in_hdr_sz), .in_data_sz(in_data_sz), .in_hdr_addr(in_hdr_addr),
        .in_data_addr(in_data_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_cmd(out_cmd), .out_ch(out_ch), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Hand-placed field layout, LSB first: type, data size, data addr, channel, seq, hdr size, hdr addr
    function automatic logic [CMD_W-1:0] makeCmd(input int ch, input logic [7:0] hs, input logic [15:0] ds,
                                                 input logic [15:0] ha, input logic [15:0] da,
                                                 input logic [7:0] seq);
        logic [CMD_W-1:0] c;
        logic [1:0]       chBits;
        chBits    = 2'(ch);
        c         = '0;
        c[3:0]    = 4'h3;
        c[19:4]   = ds;
        c[35:20]  = da;
        c[37:36]  = chBits;
        c[45:38]  = seq;
        c[53:46]  = hs;
        c[69:54]  = ha;
        return c;
    endfunction

    function automatic logic [7:0]  genHs(input int ch, input int n); return 8'(16 * ch + n); endfunction
    function automatic logic [15:0] genDs(input int ch, input int n); return 16'(4096 * ch + n); endfunction
    function automatic logic [15:0] genHa(input int ch, input int n); return 16'(40960 + 256 * ch + n); endfunction
    function automatic logic [15:0] genDa(input int ch, input int n); return 16'(12288 + 16 * ch + 7 * n); endfunction

    task automatic checkOutput(input string name, input logic [CMD_W-1:0] actual, input logic [CMD_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] hs, input logic [15:0] ds,
                                 input logic [15:0] ha, input logic [15:0] da, input bit doExpect);
        exp_t       e;
        logic [7:0] seq;
        in_hdr_sz[ch*HS_W +: HS_W]    = hs;
        in_data_sz[ch*DS_W +: DS_W]   = ds;
        in_hdr_addr[ch*HA_W +: HA_W]  = ha;
        in_data_addr[ch*DA_W +: DA_W] = da;
        in_valid[ch]                  = 1'b1;
        if (doExpect) begin
`ifdef RPU_RCV_RSP_SEQ_EN
            seq = 8'(seqModel[ch]);
            seqModel[ch] = (seqModel[ch] + 1) % 256;
`else
            seq = 8'h00;
`endif
            e.ch  = 2'(ch);
            e.cmd = makeCmd(ch, hs, ds, ha, da, seq);
            expQ.push_back(e);
        end
    endtask

    task automatic pushGen(input int ch, input int n, input bit doExpect);
        applyStimulus(ch, genHs(ch, n), genDs(ch, n), genHa(ch, n), genDa(ch, n), doExpect);
    endtask

    task automatic applyReset();
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = '1;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        for (int i = 0; i < NUM_CH; i++) seqModel[i] = 0;
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_cmd", out_cmd, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_ovf", ovf, 0);
    endtask

    task automatic waitDrain(input int maxCyc);
        int n = 0;
        while ((expQ.size() != 0 || out_valid) && n < maxCyc) begin
            @(posedge clk); #2;
            n++;
        end
        if (expQ.size() != 0 || out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending required 0", expQ.size());
        end
    endtask

    // Monitor: every accepted output must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (seenOut == markCount) firstCyc = cyc;
            lastCyc = cyc;
            seenOut++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got ch=%0d cmd=%0h required none", out_ch, out_cmd);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("out_ch", out_ch, e.ch);
                checkOutput("out_cmd", out_cmd, e.cmd);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyReset();

        $display("[TB] single push on channel 2");
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(2, 8'd5, 16'h0040, 16'h0012, 16'h0300, 1'b1);
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk);
        checkOutput("latency_edge_k", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_edge_k1", out_valid, 1);
        checkOutput("fld_type", out_cmd[3:0], 4'h3);
        checkOutput("fld_data_sz", out_cmd[19:4], 16'h0040);
        checkOutput("fld_data_addr", out_cmd[35:20], 16'h0300);
        checkOutput("fld_ch", out_cmd[37:36], 2'd2);
        checkOutput("fld_seq", out_cmd[45:38], 8'd0);
        checkOutput("fld_hdr_sz", out_cmd[53:46], 8'd5);
        checkOutput("fld_hdr_addr", out_cmd[69:54], 16'h0012);
        checkOutput("fld_pad", out_cmd[127:70], 0);
        waitDrain(10);

        $display("[TB] all channels push DEPTH entries");
        applyReset();
        out_ready = 1'b1;
        markCount = seenOut;
        for (int n = 0; n < DEPTH; n++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NUM_CH; ch++) pushGen(ch, n, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = '0;
        waitDrain(40);
        checkOutput("rr_out_count", seenOut - markCount, 16);
        checkOutput("rr_no_idle", lastCyc - firstCyc, 15);

        $display("[TB] backpressure on channel 1");
        applyReset();
        markCount = seenOut;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (n == DEPTH) checkOutput("bp_in_ready_open", in_ready[1], 1);
            if (n == DEPTH + 1) checkOutput("bp_in_ready_full", in_ready[1], 0);
            if (n >= 2) begin
                checkOutput("bp_valid_held", out_valid, 1);
                checkOutput("bp_cmd_stable", out_cmd, makeCmd(1, genHs(1, 0), genDs(1, 0), genHa(1, 0), genDa(1, 0), 8'd0));
            end
            pushGen(1, n, n <= DEPTH);
        end
        @(posedge clk); #1;
        in_valid = '0;
        checkOutput("bp_ovf", ovf, 4'b0010);
        out_ready = 1'b1;
        waitDrain(20);
        checkOutput("bp_out_count", seenOut - markCount, DEPTH + 1);

        $display("[TB] full FIFO with simultaneous pop and push");
        applyReset();
        markCount = seenOut;
        for (int n = 0; n <= DEPTH; n++) begin
            @(posedge clk); #1;
            pushGen(1, n, 1'b1);
        end
        @(posedge clk); #1;
        checkOutput("pp_ovf_before", ovf, 0);
        out_ready = 1'b1;
        pushGen(1, DEPTH + 1, 1'b0);
        checkOutput("pp_in_ready", in_ready[1], 0);
        @(posedge clk); #1;
        in_valid = '0;
        checkOutput("pp_ovf", ovf, 4'b0010);
        waitDrain(20);
        checkOutput("pp_out_count", seenOut - markCount, DEPTH + 1);

        $display("[TB] reset with buffered entries");
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            pushGen(0, n, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = '0;
        @(negedge clk);
        checkOutput("mid_valid_before", out_valid, 1);
        applyReset();
        out_ready = 1'b1;
        markCount = seenOut;
        repeat (10) @(negedge clk);
        checkOutput("mid_no_stale", seenOut - markCount, 0);
        checkOutput("mid_valid_after", out_valid, 0);

        $display("[TB] 257 packets on channel 0");
        markCount = seenOut;
        for (int n = 0; n < 257; n++) begin
            @(posedge clk); #1;
            pushGen(0, n, 1'b1);
        end
        @(posedge clk); #1;
        in_valid = '0;
        waitDrain(30);
        checkOutput("seq_out_count", seenOut - markCount, 257);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
